syncer_pulse_pacer: RTL and testbench

- Source-domain stage placed directly upstream of syncer_pulse.
- syncer_pulse silently drops a new pulse while its req/ack handshake is still in flight. It also detects rising edges only, so back-to-back strobes merge.
- This block accepts bursty single-cycle event strobes, counts them as a pending backlog, and re-emits them as isolated single-cycle pulses. Pulse starts are spaced at least GAP_CYCLES apart, so every event crosses the domain boundary.

---
 rtl/syncer_pulse_pacer.sv | 103 ++++++++++
 tb/tb_syncer_pulse_pacer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/syncer_pulse_pacer.sv
// Paces bursty event strobes into isolated pulse_out pulses spaced GAP_CYCLES apart; 1-cycle idle latency, no backpressure (backlog counted, sticky overflow when full).
// Optional SYNCER_PULSE_PACER_DROP_CNT_EN adds a saturating drop_cnt of events lost to overflow.
module syncer_pulse_pacer #(
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             event_in,
  input  logic             flush,
  input  logic             overflow_clr,
  output logic             pulse_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
  output logic [15:0]      drop_cnt,
`endif
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = '1;
  localparam logic [15:0]      GAP_LOAD = 16'(GAP_CYCLES - 2);

  state_t           state, state_nxt;
  logic [15:0]      gap_cnt, gap_cnt_nxt;
  logic [CNT_W-1:0] pending_nxt;
  logic             launch;
  logic             ovf_evt;

  always_comb begin
    launch      = (state == IDLE) && ((pending != '0) || event_in) && !flush;
    ovf_evt     = event_in && !flush && !launch && (pending == PEND_MAX);
    pending_nxt = pending;
    if (flush) begin
      pending_nxt = '0;
    end else if (event_in && !launch) begin
      if (pending != PEND_MAX) pending_nxt = pending + CNT_W'(1);
    end else if (!event_in && launch) begin
      pending_nxt = pending - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: if (launch) state_nxt = PULSE;
      PULSE: begin
        // With a 2-cycle gap the single idle cycle already provides the spacing.
        if (GAP_CYCLES > 2) begin
          state_nxt   = GAP;
          gap_cnt_nxt = GAP_LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      GAP: begin
        gap_cnt_nxt = gap_cnt - 16'd1;
        if (gap_cnt == 16'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      pending   <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      gap_cnt   <= gap_cnt_nxt;
      pending   <= pending_nxt;
      pulse_out <= (state_nxt == PULSE);
      busy      <= (state_nxt != IDLE) || (pending_nxt != '0);
      overflow  <= ovf_evt || (overflow && !overflow_clr);
    end
  end

`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
  logic [15:0] drop_cnt_nxt;

  always_comb begin
    drop_cnt_nxt = drop_cnt;
    if (overflow_clr) begin
      drop_cnt_nxt = ovf_evt ? 16'd1 : 16'd0;
    end else if (ovf_evt && (drop_cnt != 16'hFFFF)) begin
      drop_cnt_nxt = drop_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) drop_cnt <= '0;
    else         drop_cnt <= drop_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_syncer_pulse_pacer.sv
// Scoreboard bench: expected pulse cycles are queued by stimulus and popped by a negedge monitor.
module tb_syncer_pulse_pacer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetn;
  logic       ev_a, fl_a, oc_a, pls_a, busy_a, ovf_a;
  logic [2:0] pend_a;
  logic       ev_b, fl_b, oc_b, pls_b, busy_b, ovf_b;
  logic [7:0] pend_b;
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
  logic [15:0] drop_a, drop_b;
`endif

  syncer_pulse_pacer #(.CNT_W(3), .GAP_CYCLES(16)) u_a (
    .clk(clk), .resetn(resetn), .event_in(ev_a), .flush(fl_a), .overflow_clr(oc_a),
    .pulse_out(pls_a), .pending(pend_a), .busy(busy_a),
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
    .drop_cnt(drop_a),
`endif
    .overflow(ovf_a)
  );

  syncer_pulse_pacer #(.CNT_W(8), .GAP_CYCLES(2)) u_b (
    .clk(clk), .resetn(resetn), .event_in(ev_b), .flush(fl_b), .overflow_clr(oc_b),
    .pulse_out(pls_b), .pending(pend_b), .busy(busy_b),
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
    .drop_cnt(drop_b),
`endif
    .overflow(ovf_b)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int qa[$];
  int qb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every pulse must match the next expected pulse cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (pls_a) begin
        if (qa.size() == 0) check("pulse_a_unexpected", cyc, -1);
        else                check("pulse_a_cycle", cyc, qa.pop_front());
      end
      if (pls_b) begin
        if (qb.size() == 0) check("pulse_b_unexpected", cyc, -1);
        else                check("pulse_b_cycle", cyc, qb.pop_front());
      end
    end
  end

  initial begin
    int t0;
    int mx;
    resetn = 1'b0;
    ev_a = 0; fl_a = 0; oc_a = 0;
    ev_b = 0; fl_b = 0; oc_b = 0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    check("rst_pulse_a", pls_a, 0);
    check("rst_pending_a", pend_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_overflow_a", ovf_a, 0);
    check("rst_pulse_b", pls_b, 0);
    check("rst_pending_b", pend_b, 0);
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
    check("rst_drop_a", drop_a, 0);
`endif

    // Single event at cycle 10: pulse at 11, busy 11..25, pending stays 0.
    t0 = cyc;
    qa.push_back(t0 + 11);
    for (int i = 0; i < 30; i++) begin
      check("t1_pending", pend_a, 0);
      check("t1_busy", busy_a, (i >= 11 && i <= 25) ? 1 : 0);
      ev_a = (i == 10);
      tick();
    end
    ev_a = 0;

    // Burst of 5: pulses at 1,17,33,49,65; pending peaks at 4; busy drops at 80.
    t0 = cyc;
    mx = 0;
    for (int k = 0; k < 5; k++) qa.push_back(t0 + 1 + 16 * k);
    for (int i = 0; i < 90; i++) begin
      if (int'(pend_a) > mx) mx = int'(pend_a);
      if (i == 5)  check("t2_pending_c5", pend_a, 4);
      if (i == 79) check("t2_busy_c79", busy_a, 1);
      if (i == 80) check("t2_busy_c80", busy_a, 0);
      ev_a = (i < 5);
      tick();
    end
    check("t2_pending_peak", mx, 4);
    check("t2_pending_end", pend_a, 0);

    // Minimum gap (GAP_CYCLES=2): event held 6 cycles -> pulses at 1,3,5,7,9,11.
    t0 = cyc;
    for (int k = 0; k < 6; k++) qb.push_back(t0 + 1 + 2 * k);
    for (int i = 0; i < 20; i++) begin
      if (i == 6) check("t3_pending_c6", pend_b, 3);
      ev_b = (i < 6);
      tick();
    end
    check("t3_overflow", ovf_b, 0);
    check("t3_pending_end", pend_b, 0);
    check("t3_busy_end", busy_b, 0);

    // Overflow: 12 back-to-back events into a 3-bit backlog -> 8 pulses, 4 dropped.
    t0 = cyc;
    for (int k = 0; k < 8; k++) qa.push_back(t0 + 1 + 16 * k);
    for (int i = 0; i < 130; i++) begin
      if (i == 12) begin
        check("t4_pending_sat", pend_a, 7);
        check("t4_overflow_set", ovf_a, 1);
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
        check("t4_drop_cnt", drop_a, 4);
`endif
      end
      if (i == 129) check("t4_overflow_sticky", ovf_a, 1);
      ev_a = (i < 12);
      tick();
    end
    oc_a = 1'b1;
    tick();
    oc_a = 1'b0;
    check("t4_overflow_clr", ovf_a, 0);
`ifdef SYNCER_PULSE_PACER_DROP_CNT_EN
    check("t4_drop_clr", drop_a, 0);
`endif

    // Flush during GAP with event_in high: GAP completes, backlog gone, no more pulses.
    t0 = cyc;
    qa.push_back(t0 + 1);
    for (int i = 0; i < 40; i++) begin
      if (i == 6)  check("t5_pending_pre", pend_a, 5);
      if (i == 9)  check("t5_pending_flushed", pend_a, 0);
      if (i == 15) check("t5_busy_gap", busy_a, 1);
      if (i == 16) check("t5_busy_done", busy_a, 0);
      ev_a = (i < 6) || (i == 8);
      fl_a = (i == 8);
      tick();
    end
    check("t5_overflow", ovf_a, 0);
    check("t5_pending_end", pend_a, 0);

    repeat (3) tick();
    check("pulse_a_leftover", qa.size(), 0);
    check("pulse_b_leftover", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
